// File: rtl/battle_referee_pkg.sv
// Shared battle-referee definitions: game-state encodings, limits and the attack table.
package battle_referee_pkg;

  typedef enum logic [2:0] {
    STATE_MENU    = 3'd0,
    STATE_GAME    = 3'd1,
    STATE_1P_GAME = 3'd2,
    STATE_P1_WINS = 3'd3,
    STATE_P2_WINS = 3'd4,
    STATE_OVER    = 3'd5
  } game_state_e;

  localparam int unsigned GARBAGE_MAX_DEF = 12;
  localparam int unsigned KO_MAX          = 5;
  localparam int unsigned LINE_MAX        = 63;
  localparam int unsigned ATK_W           = 3;
  localparam int unsigned PEND_W          = 4;

  // Attack rows produced by a clear of the given number of lines.
  function automatic logic [ATK_W-1:0] attack(input logic [2:0] lines);
    case (lines)
      3'd2:    attack = ATK_W'(1);
      3'd3:    attack = ATK_W'(2);
      3'd4:    attack = ATK_W'(4);
      default: attack = ATK_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/battle_referee_garbage_queue.sv
// One player's pending-garbage counter: take, own cancellation, incoming overflow, saturation.
module battle_referee_garbage_queue
  import battle_referee_pkg::*;
#(
  parameter int unsigned GARBAGE_MAX = GARBAGE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              take,
  input  logic [ATK_W-1:0]  atk,
  input  logic [ATK_W-1:0]  ovf_in,
  output logic [PEND_W-1:0] pend,
  output logic              valid,
  output logic [ATK_W-1:0]  ovf_c
);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [PEND_W-1:0] p_taken, cancel, p_left;
  logic [PEND_W:0]   sum;

  always_comb begin
    p_taken = take ? '0 : pend_q;
    cancel  = (PEND_W'(atk) < p_taken) ? PEND_W'(atk) : p_taken;
    p_left  = p_taken - cancel;
    ovf_c   = atk - ATK_W'(cancel);
    sum     = (PEND_W+1)'(p_left) + (PEND_W+1)'(ovf_in);
    pend_d  = pend_q;
    if (clr) begin
      pend_d = '0;
    end else if (en) begin
      pend_d = (sum > (PEND_W+1)'(GARBAGE_MAX)) ? PEND_W'(GARBAGE_MAX) : PEND_W'(sum);
    end
    valid_d = (pend_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  assign pend  = pend_q;
  assign valid = valid_q;

endmodule

// File: rtl/battle_referee.sv
// Per-match bookkeeping: KO counts, lines sent, match timer and garbage routing between players.
module battle_referee
  import battle_referee_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned MATCH_SEC   = 120,
  parameter int unsigned GARBAGE_MAX = GARBAGE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        clear_valid,
  input  logic        clear_valid_2,
  input  logic [2:0]  clear_lines,
  input  logic [2:0]  clear_lines_2,
  input  logic        topout,
  input  logic        topout_2,
  input  logic        garbage_take,
  input  logic        garbage_take_2,
  output logic        garbage_valid,
  output logic        garbage_valid_2,
  output logic [3:0]  garbage_rows,
  output logic [3:0]  garbage_rows_2,
  output logic [2:0]  ko,
  output logic [2:0]  ko_2,
  output logic [5:0]  line_sended,
  output logic [5:0]  line_sended_2,
  output logic [7:0]  time_left,
  output logic        time_up,
  output logic        board_reset,
  output logic        board_reset_2
);

  localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic             was_active_q, was_active_d;
  logic [2:0]       ko_q, ko_d, ko2_q, ko2_d;
  logic [5:0]       line_q, line_d, line2_q, line2_d;
  logic [7:0]       tl_q, tl_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tu_q, tu_d, br_q, br_d, br2_q, br2_d;

  logic             active, entry, live, live2p;
  logic [ATK_W-1:0] atk1, atk2, q_atk1, q_atk2, ovf1, ovf2;
  logic [6:0]       line_sum, line2_sum;

  // Event qualification: the entry cycle only reinitialises, a top-out drops the same player's clear.
  always_comb begin
    active = (state == STATE_GAME) || (state == STATE_1P_GAME);
    entry  = active && !was_active_q;
    live   = active && !entry;
    live2p = live && (state == STATE_GAME);
    atk1   = (live && clear_valid && !topout) ? attack(clear_lines) : '0;
    atk2   = (live && clear_valid_2 && !topout_2) ? attack(clear_lines_2) : '0;
    q_atk1 = live2p ? atk1 : '0;
    q_atk2 = live2p ? atk2 : '0;
  end

  always_comb begin
    was_active_d = active;
    ko_d         = ko_q;
    ko2_d        = ko2_q;
    line_sum     = 7'(line_q) + 7'(atk1);
    line2_sum    = 7'(line2_q) + 7'(atk2);
    line_d       = (line_sum > 7'(LINE_MAX)) ? 6'(LINE_MAX) : 6'(line_sum);
    line2_d      = (line2_sum > 7'(LINE_MAX)) ? 6'(LINE_MAX) : 6'(line2_sum);
    tl_d         = tl_q;
    div_d        = div_q;
    br_d         = live && topout;
    br2_d        = live && topout_2;
    tu_d         = live && (tl_q == 8'd0);
    if (live2p && topout_2 && (ko_q != 3'(KO_MAX))) ko_d = ko_q + 3'd1;
    if (live2p && topout && (ko2_q != 3'(KO_MAX))) ko2_d = ko2_q + 3'd1;
    if (entry) begin
      ko_d    = '0;
      ko2_d   = '0;
      line_d  = '0;
      line2_d = '0;
      tl_d    = 8'(MATCH_SEC);
      div_d   = '0;
    end else if (active) begin
      if (div_q == DIV_W'(CLK_HZ - 1)) begin
        div_d = '0;
        if (tl_q != 8'd0) tl_d = tl_q - 8'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      line_d  = line_q;
      line2_d = line2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      was_active_q <= 1'b0;
      ko_q         <= '0;
      ko2_q        <= '0;
      line_q       <= '0;
      line2_q      <= '0;
      tl_q         <= 8'(MATCH_SEC);
      div_q        <= '0;
      tu_q         <= 1'b0;
      br_q         <= 1'b0;
      br2_q        <= 1'b0;
    end else begin
      was_active_q <= was_active_d;
      ko_q         <= ko_d;
      ko2_q        <= ko2_d;
      line_q       <= line_d;
      line2_q      <= line2_d;
      tl_q         <= tl_d;
      div_q        <= div_d;
      tu_q         <= tu_d;
      br_q         <= br_d;
      br2_q        <= br2_d;
    end
  end

  // pend1 receives P2's overflow, pend2 receives P1's.
  battle_referee_garbage_queue #(.GARBAGE_MAX(GARBAGE_MAX)) u_queue_p1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (entry || (live && topout)),
    .en     (live2p),
    .take   (garbage_take),
    .atk    (q_atk1),
    .ovf_in (ovf2),
    .pend   (garbage_rows),
    .valid  (garbage_valid),
    .ovf_c  (ovf1)
  );

  battle_referee_garbage_queue #(.GARBAGE_MAX(GARBAGE_MAX)) u_queue_p2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (entry || (live && topout_2)),
    .en     (live2p),
    .take   (garbage_take_2),
    .atk    (q_atk2),
    .ovf_in (ovf1),
    .pend   (garbage_rows_2),
    .valid  (garbage_valid_2),
    .ovf_c  (ovf2)
  );

  assign ko            = ko_q;
  assign ko_2          = ko2_q;
  assign line_sended   = line_q;
  assign line_sended_2 = line2_q;
  assign time_left     = tl_q;
  assign time_up       = tu_q;
  assign board_reset   = br_q;
  assign board_reset_2 = br2_q;

endmodule

// File: tb/tb_battle_referee.sv
// Self-checking bench for battle_referee: directed vector table, timer/reset sequences, random vs model.
module tb_battle_referee;
  import battle_referee_pkg::*;

  localparam int CLK_HZ_T = 4;
  localparam int MATCH_T  = 2;
  localparam int GMAX_T   = 12;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] state;
  logic clear_valid, clear_valid_2, topout, topout_2, garbage_take, garbage_take_2;
  logic [2:0] clear_lines, clear_lines_2;
  logic garbage_valid, garbage_valid_2, time_up, board_reset, board_reset_2;
  logic [3:0] garbage_rows, garbage_rows_2;
  logic [2:0] ko, ko_2;
  logic [5:0] line_sended, line_sended_2;
  logic [7:0] time_left;

  always #5 clk = ~clk;

  battle_referee #(.CLK_HZ(CLK_HZ_T), .MATCH_SEC(MATCH_T), .GARBAGE_MAX(GMAX_T)) dut (
    .clk(clk), .rst(rst), .state(state),
    .clear_valid(clear_valid), .clear_valid_2(clear_valid_2),
    .clear_lines(clear_lines), .clear_lines_2(clear_lines_2),
    .topout(topout), .topout_2(topout_2),
    .garbage_take(garbage_take), .garbage_take_2(garbage_take_2),
    .garbage_valid(garbage_valid), .garbage_valid_2(garbage_valid_2),
    .garbage_rows(garbage_rows), .garbage_rows_2(garbage_rows_2),
    .ko(ko), .ko_2(ko_2), .line_sended(line_sended), .line_sended_2(line_sended_2),
    .time_left(time_left), .time_up(time_up),
    .board_reset(board_reset), .board_reset_2(board_reset_2)
  );

  int checks = 0;
  int failures = 0;
  int atk_tab[8] = '{0, 0, 1, 2, 4, 0, 0, 0};

  int m_p1, m_p2, m_l1, m_l2, m_k1, m_k2, m_tl, m_div, m_tu, m_br1, m_br2;
  bit m_prev;

  typedef struct {
    logic [2:0] st;
    logic cv1; logic [2:0] cl1;
    logic cv2; logic [2:0] cl2;
    logic to1, to2, tk1, tk2;
    int p1, p2, l1, l2, k1, k2;
  } vec_t;
  vec_t vecs[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_l1 = 0; m_l2 = 0; m_k1 = 0; m_k2 = 0;
    m_tl = MATCH_T; m_div = 0; m_tu = 0; m_br1 = 0; m_br2 = 0; m_prev = 0;
  endtask

  // Advance the reference model by one clock using the inputs currently driven.
  task automatic model_step();
    bit act, ent, two;
    int a1, a2, p1, p2, c1, c2, o1, o2;
    act = (state == STATE_GAME) || (state == STATE_1P_GAME);
    ent = act && !m_prev;
    two = (state == STATE_GAME);
    m_br1 = 0; m_br2 = 0;
    if (!act) begin
      m_tu = 0;
    end else if (ent) begin
      m_p1 = 0; m_p2 = 0; m_l1 = 0; m_l2 = 0; m_k1 = 0; m_k2 = 0;
      m_tl = MATCH_T; m_div = 0; m_tu = 0;
    end else begin
      m_tu = (m_tl == 0);
      a1 = (clear_valid && !topout) ? atk_tab[clear_lines] : 0;
      a2 = (clear_valid_2 && !topout_2) ? atk_tab[clear_lines_2] : 0;
      m_l1 = imin(63, m_l1 + a1);
      m_l2 = imin(63, m_l2 + a2);
      if (two) begin
        p1 = garbage_take ? 0 : m_p1;
        p2 = garbage_take_2 ? 0 : m_p2;
        c1 = imin(a1, p1); p1 -= c1; o1 = a1 - c1;
        c2 = imin(a2, p2); p2 -= c2; o2 = a2 - c2;
        m_p1 = imin(p1 + o2, GMAX_T);
        m_p2 = imin(p2 + o1, GMAX_T);
        if (topout_2) m_k1 = imin(5, m_k1 + 1);
        if (topout) m_k2 = imin(5, m_k2 + 1);
      end
      if (topout) begin m_p1 = 0; m_br1 = 1; end
      if (topout_2) begin m_p2 = 0; m_br2 = 1; end
      if (m_div == CLK_HZ_T - 1) begin
        m_div = 0;
        if (m_tl > 0) m_tl--;
      end else begin
        m_div++;
      end
    end
    m_prev = act;
  endtask

  task automatic check_model();
    chk("garbage_rows", garbage_rows, m_p1);
    chk("garbage_rows_2", garbage_rows_2, m_p2);
    chk("garbage_valid", garbage_valid, m_p1 != 0);
    chk("garbage_valid_2", garbage_valid_2, m_p2 != 0);
    chk("line_sended", line_sended, m_l1);
    chk("line_sended_2", line_sended_2, m_l2);
    chk("ko", ko, m_k1);
    chk("ko_2", ko_2, m_k2);
    chk("time_left", time_left, m_tl);
    chk("time_up", time_up, m_tu);
    chk("board_reset", board_reset, m_br1);
    chk("board_reset_2", board_reset_2, m_br2);
  endtask

  task automatic idle_inputs();
    clear_valid = 0; clear_valid_2 = 0; clear_lines = 0; clear_lines_2 = 0;
    topout = 0; topout_2 = 0; garbage_take = 0; garbage_take_2 = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  function automatic vec_t mk(input logic [2:0] st, input logic cv1, input logic [2:0] cl1,
                              input logic cv2, input logic [2:0] cl2, input logic to1, input logic to2,
                              input logic tk1, input logic tk2, input int p1, input int p2,
                              input int l1, input int l2, input int k1, input int k2);
    vec_t v;
    v.st = st; v.cv1 = cv1; v.cl1 = cl1; v.cv2 = cv2; v.cl2 = cl2;
    v.to1 = to1; v.to2 = to2; v.tk1 = tk1; v.tk2 = tk2;
    v.p1 = p1; v.p2 = p2; v.l1 = l1; v.l2 = l2; v.k1 = k1; v.k2 = k2;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    state = STATE_MENU;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_time_left", time_left, MATCH_T);
    chk("rst_ko", ko, 0);
    chk("rst_time_up", time_up, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //        st             cv1 cl1 cv2 cl2 to1 to2 tk1 tk2  p1  p2  l1  l2  k1  k2
    vecs.push_back(mk(STATE_MENU,    0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0,  4,  4,  0,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 1, 3, 0, 0, 0, 0,  0,  2,  4,  2,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 0, 0, 1,  0,  0,  4,  2,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 1, 3, 0, 0, 0, 0,  2,  0,  4,  4,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 1, 2, 0, 0, 0, 0,  3,  0,  4,  5,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 1, 4, 0, 0, 0, 0,  4,  1,  8,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 0, 1, 1,  0,  0,  8,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0,  4, 12,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0,  8, 16,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0, 12, 20,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0, 12, 24,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 24,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 0, 0, 1,  0,  0, 24,  9,  0,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 1, 4, 0, 1, 0, 0,  0,  0, 24,  9,  1,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 24,  9,  2,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 24,  9,  3,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 24,  9,  4,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 24,  9,  5,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 0, 1, 0, 0,  0,  0, 24,  9,  5,  0));
    vecs.push_back(mk(STATE_GAME,    0, 0, 0, 0, 1, 1, 0, 0,  0,  0, 24,  9,  5,  1));
    vecs.push_back(mk(STATE_P1_WINS, 1, 4, 0, 0, 0, 0, 0, 0,  0,  0, 24,  9,  5,  1));
    vecs.push_back(mk(STATE_GAME,    1, 4, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(STATE_MENU,    0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 1, 4, 0, 0, 0, 0, 0, 0,  0,  0,  4,  0,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0,  4,  0,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 0, 0, 1, 2, 0, 0, 0, 1,  0,  0,  4,  1,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 1, 1, 0, 0, 0, 0, 0, 0,  0,  0,  4,  1,  0,  0));
    vecs.push_back(mk(STATE_1P_GAME, 1, 7, 0, 0, 0, 0, 0, 0,  0,  0,  4,  1,  0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      state = vecs[i].st;
      clear_valid = vecs[i].cv1; clear_lines = vecs[i].cl1;
      clear_valid_2 = vecs[i].cv2; clear_lines_2 = vecs[i].cl2;
      topout = vecs[i].to1; topout_2 = vecs[i].to2;
      garbage_take = vecs[i].tk1; garbage_take_2 = vecs[i].tk2;
      tick();
      chk($sformatf("vec%0d_rows", i), garbage_rows, vecs[i].p1);
      chk($sformatf("vec%0d_rows_2", i), garbage_rows_2, vecs[i].p2);
      chk($sformatf("vec%0d_line", i), line_sended, vecs[i].l1);
      chk($sformatf("vec%0d_line_2", i), line_sended_2, vecs[i].l2);
      chk($sformatf("vec%0d_ko", i), ko, vecs[i].k1);
      chk($sformatf("vec%0d_ko_2", i), ko_2, vecs[i].k2);
      if (i == 27) chk("vec27_board_reset", board_reset, 1);
      if (i == 21) chk("vec21_board_reset_2", board_reset_2, 1);
    end
    idle_inputs();

    // Lines-sent saturation in 1P: 16 tetrises on top of 4.
    for (int i = 0; i < 16; i++) begin
      clear_valid = 1; clear_lines = 4;
      tick();
    end
    chk("line_sat", line_sended, 63);
    idle_inputs();

    // Timer: CLK_HZ=4, MATCH_SEC=2.
    state = STATE_MENU;
    tick();
    state = STATE_GAME;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("timer%0d_left", i), time_left, (i < 4) ? 2 : (i < 8) ? 1 : 0);
      chk($sformatf("timer%0d_up", i), time_up, (i >= 9) ? 1 : 0);
    end
    state = STATE_P1_WINS;
    tick();
    chk("timer_up_drop", time_up, 0);
    chk("timer_left_hold", time_left, 0);
    state = STATE_GAME;
    tick();
    chk("timer_reentry_left", time_left, MATCH_T);
    chk("timer_reentry_up", time_up, 0);

    // Asynchronous reset mid-match.
    topout_2 = 1; clear_valid = 1; clear_lines = 4;
    tick();
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_ko", ko, 0);
    chk("arst_line", line_sended, 0);
    chk("arst_rows_2", garbage_rows_2, 0);
    chk("arst_time_left", time_left, MATCH_T);
    @(negedge clk);
    rst = 1'b0;
    state = STATE_MENU;
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        if (state == STATE_GAME || state == STATE_1P_GAME)
          state = 3'($urandom_range(3, 5));
        else
          state = 3'($urandom_range(0, 5));
      end
      clear_valid = ($urandom_range(0, 2) == 0);
      clear_lines = 3'($urandom_range(0, 7));
      clear_valid_2 = ($urandom_range(0, 2) == 0);
      clear_lines_2 = 3'($urandom_range(0, 7));
      topout = ($urandom_range(0, 29) == 0);
      topout_2 = ($urandom_range(0, 29) == 0);
      garbage_take = ($urandom_range(0, 7) == 0);
      garbage_take_2 = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/battle_referee.md
# battle_referee

Per-match battle bookkeeping that feeds the game-flow controller. Consumes line-clear and top-out events from both board engines and produces KO counts, lines-sent totals, the match timer and `time_up`. Also routes garbage rows between players with cancellation. Sits between the two board engines and `system_control`, and reads back its `state`.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per one-second tick.
- `MATCH_SEC`, default 120: match length in seconds, 1–255.
- `GARBAGE_MAX`, default 12: saturation limit of each pending-garbage counter, 1–15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `state` in 3: game state from the flow controller (`STATE_*` encodings).
- `clear_valid`, `clear_valid_2` in 1: one-cycle line-clear strobe, P1/P2.
- `clear_lines`, `clear_lines_2` in 3: rows cleared, 1–4; valid only with the strobe.
- `topout`, `topout_2` in 1: one-cycle top-out strobe, P1/P2.
- `garbage_take`, `garbage_take_2` in 1: board accepts all offered garbage this cycle.
- `garbage_valid`, `garbage_valid_2` out 1: garbage is pending for P1/P2.
- `garbage_rows`, `garbage_rows_2` out 4: pending row count for P1/P2.
- `ko`, `ko_2` out 3: KOs scored by P1/P2, saturating at 5.
- `line_sended`, `line_sended_2` out 6: attack lines sent by P1/P2, saturating at 63.
- `time_left` out 8: remaining seconds.
- `time_up` out 1: level; timer expired.
- `board_reset`, `board_reset_2` out 1: one-cycle pulse that restarts a topped-out board.

## Operation
- **Active window.** Active means `state` is `STATE_GAME` (2P) or `STATE_1P_GAME` (1P). All event inputs are ignored outside the active window.
- **Match entry.** On the first cycle `state` is active after being non-active:
  - clear `ko`, `ko_2`, `line_sended`, `line_sended_2` and both pending counters;
  - load `time_left` = `MATCH_SEC`;
  - reset the tick divider.
  - Events arriving on the entry cycle are dropped.
- **Outside the active window.** Statistics and `time_left` hold their values so they can be shown in the WINS/OVER screens.
- **Attack table.** Attack a = f(`clear_lines`): 1→0, 2→1, 3→2, 4→4. Values 0 and 5–7 give 0.
  - Each clear adds the full a to that player's `line_sended`, saturating at 63, in both modes.
- **Garbage, 2P only.** Rows queued for P1 are in `pend1`; rows queued for P2 are in `pend2`. Per-cycle order for `pend1`:
  1. If `garbage_take`, p = 0; otherwise p = `pend1`.
  2. Own cancellation: c = min(a1, p), p = p − c. The overflow o1 = a1 − c.
  3. Incoming: p = min(p + o2, `GARBAGE_MAX`), where o2 is P2's overflow computed the same way in the same cycle.
  - `pend2` is symmetric.
  - Simultaneous clears from both players each cancel against their own pre-cycle value, then cross-add.
  - `garbage_valid` = (pend ≠ 0). `garbage_rows` = pend.
  - A take while pend = 0 is a no-op.
- **1P mode.** Pending counters stay 0, `garbage_valid*` stay 0, takes are ignored.
- **KO.** In 2P, `topout_2` increments `ko` and `topout` increments `ko_2`, each saturating at 5.
  - Every top-out in either mode pulses that player's `board_reset` the next cycle and clears that player's pending counter.
  - Both players topping out in the same cycle increments both KO counts.
  - A top-out and a clear from the same player in one cycle: the top-out wins and the clear is dropped.
- **Timer.** Active only. The divider counts 0..`CLK_HZ`−1. On wrap, `time_left` decrements if it is nonzero.
  - `time_up` = active && `time_left` == 0. It deasserts when the window ends.
  - `time_left` never wraps below 0.

## Timing
- All outputs are registered. Every event is reflected one cycle after its strobe.
- `time_up` asserts in the cycle after `time_left` becomes 0.
- Reset values:
  - `ko`, `ko_2`, `line_sended*`, `garbage_rows*`, `garbage_valid*`, `board_reset*`, `time_up`: 0.
  - `time_left`: `MATCH_SEC`.
  - Divider: 0.
- Reset mid-match returns everything to these values immediately (asynchronous).

## Structure
- The attack table function, the `GARBAGE_MAX` default, and the `STATE_*` encodings belong in the shared `global.v` defines.
- One natural sub-module: `garbage_queue`, instantiated twice. It holds one pending counter with its take / cancel / incoming / saturate logic and exports its overflow.

## Test plan
- **Clears and cancellation.** Enter `STATE_GAME`; P1 clears 4 → `pend2`=4, `line_sended`=4. P2 clears 3 → `pend2`=2, `pend1`=0, `line_sended_2`=2.
- **Simultaneous clears.** With `pend1`=3 and `pend2`=0, same-cycle clears of P1=4 and P2=4 → `pend1`=4 (3 cancelled, 4 incoming), `pend2`=1.
- **Saturation and take.** Three P1 tetrises → `pend2`=12, `line_sended`=12. `garbage_take_2` → `garbage_valid_2`=0 next cycle.
- **KO.** Five `topout_2` strobes → `ko`=5 with five `board_reset_2` pulses; a sixth strobe leaves `ko`=5. A same-cycle double top-out increments both counts.
- **Timer (`CLK_HZ`=4, `MATCH_SEC`=2).** `time_up` rises 8 cycles after entry plus 1 registration cycle, holds while active, and drops when `state`=`STATE_P1_WINS`. Stats hold; re-entering a game clears them.
- **1P mode and async reset.** `STATE_1P_GAME`: a clear of 4 gives `line_sended`=4 and `garbage_valid_2`=0; a `topout` pulses `board_reset` with `ko_2` unchanged. Asserting `rst` mid-match zeroes all counters.
